d_cache_ctrl: RTL

Direct-mapped, write-back, write-allocate data cache for the NeonFox CPU, sitting between the pipeline's data read/write stage and the SDRAM controller. It raises `d_cache_read_miss` and `d_cache_write_miss` to the hazard logic, which holds the pipeline stalled. While the pipeline is stalled, the block writes back any dirty victim line and fills the missing line one word at a time over a request/acknowledge memory port. When the access is re-presented afterwards, it hits.

---
 rtl/d_cache_ctrl_if.sv | 29 ++
 rtl/d_cache_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/d_cache_ctrl_if.sv
// CPU data-port and memory-port signals of the NeonFox data cache.
// slave = the cache itself; master = the CPU pipeline plus SDRAM side driving it.
interface d_cache_ctrl_if;
    logic        data_ren;
    logic        data_wren;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic [15:0] data_rdata;
    logic        d_cache_read_miss;
    logic        d_cache_write_miss;
    logic        mem_req;
    logic        mem_wren;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport slave (
        input  data_ren, data_wren, data_addr, data_wdata, mem_ack, mem_rdata,
        output data_rdata, d_cache_read_miss, d_cache_write_miss,
        output mem_req, mem_wren, mem_addr, mem_wdata
    );

    modport master (
        output data_ren, data_wren, data_addr, data_wdata, mem_ack, mem_rdata,
        input  data_rdata, d_cache_read_miss, d_cache_write_miss,
        input  mem_req, mem_wren, mem_addr, mem_wdata
    );
endinterface

// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache; read hit data registered (1 cycle).
// Misses stall the CPU while a dirty victim is written back and the line refilled word by word on mem_req/mem_ack.
module d_cache_ctrl #(
    parameter int LINES   = 64,
    parameter int INDEX_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    d_cache_ctrl_if.slave  bus_if
);
    localparam int TAG_W = 14 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t             state_q;
    logic [1:0]         cnt_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [15:0]        data_q [LINES*4];
    logic [TAG_W-1:0]   miss_tag_q;
    logic [INDEX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0]   victim_tag_q;
    logic [15:0]        rdata_q;
    logic               mem_req_q;
    logic               mem_wren_q;
    logic [15:0]        mem_addr_q;
    logic [15:0]        mem_wdata_q;

    logic [TAG_W-1:0]   tag_a;
    logic [INDEX_W-1:0] idx_a;
    logic [1:0]         word_a;
    logic [1:0]         cnt_nxt;
    logic               hit;
    logic               miss;
    logic               wr_hit;
    logic               fill_we;

    assign tag_a   = bus_if.data_addr[15:INDEX_W+2];
    assign idx_a   = bus_if.data_addr[INDEX_W+1:2];
    assign word_a  = bus_if.data_addr[1:0];
    assign cnt_nxt = cnt_q + 2'd1;

    assign hit     = valid_q[idx_a] && (tag_q[idx_a] == tag_a) && (state_q == IDLE);
    assign miss    = (bus_if.data_ren || bus_if.data_wren) && !hit;
    assign wr_hit  = hit && bus_if.data_wren;
    assign fill_we = (state_q == FILL) && bus_if.mem_ack;

    assign bus_if.d_cache_read_miss  = rst_n && bus_if.data_ren && !bus_if.data_wren && !hit;
    assign bus_if.d_cache_write_miss = rst_n && bus_if.data_wren && !hit;
    assign bus_if.data_rdata         = rdata_q;
    assign bus_if.mem_req            = mem_req_q;
    assign bus_if.mem_wren           = mem_wren_q;
    assign bus_if.mem_addr           = mem_addr_q;
    assign bus_if.mem_wdata          = mem_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            victim_tag_q <= '0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_hit) begin
                        dirty_q[idx_a] <= 1'b1;
                    end else if (hit && bus_if.data_ren) begin
                        rdata_q <= data_q[{idx_a, word_a}];
                    end else if (miss) begin
                        miss_tag_q   <= tag_a;
                        miss_idx_q   <= idx_a;
                        victim_tag_q <= tag_q[idx_a];
                        cnt_q        <= '0;
                        mem_req_q    <= 1'b1;
                        if (valid_q[idx_a] && dirty_q[idx_a]) begin
                            state_q     <= WB;
                            mem_wren_q  <= 1'b1;
                            mem_addr_q  <= {tag_q[idx_a], idx_a, 2'b00};
                            mem_wdata_q <= data_q[{idx_a, 2'b00}];
                        end else begin
                            state_q    <= FILL;
                            mem_wren_q <= 1'b0;
                            mem_addr_q <= {tag_a, idx_a, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (bus_if.mem_ack) begin
                        cnt_q <= cnt_nxt;
                        if (cnt_q == 2'd3) begin
                            state_q    <= FILL;
                            mem_wren_q <= 1'b0;
                            mem_addr_q <= {miss_tag_q, miss_idx_q, 2'b00};
                        end else begin
                            mem_addr_q  <= {victim_tag_q, miss_idx_q, cnt_nxt};
                            mem_wdata_q <= data_q[{miss_idx_q, cnt_nxt}];
                        end
                    end
                end
                FILL: begin
                    if (bus_if.mem_ack) begin
                        cnt_q <= cnt_nxt;
                        if (cnt_q == 2'd3) begin
                            state_q             <= IDLE;
                            mem_req_q           <= 1'b0;
                            valid_q[miss_idx_q] <= 1'b1;
                            dirty_q[miss_idx_q] <= 1'b0;
                        end else begin
                            mem_addr_q <= {miss_tag_q, miss_idx_q, cnt_nxt};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            data_q[{idx_a, word_a}] <= bus_if.data_wdata;
        end
        if (fill_we) begin
            data_q[{miss_idx_q, cnt_q}] <= bus_if.mem_rdata;
        end
        if (fill_we && (cnt_q == 2'd3)) begin
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end
endmodule
